// File: rtl/calc_disp_pkg.sv
// Shared types and constants for the calculator result display: FSM states,
// active-low seven-segment codes and the double-dabble digit adjust helper.
package calc_disp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;

    // Pre-shift correction: any BCD nibble of 5 or more gets 3 added so the
    // following left shift carries correctly into the next decade.
    function automatic logic [11:0] dabble_adjust(input logic [11:0] scratch);
        logic [11:0] adj;
        adj = scratch;
        for (int i = 0; i < 3; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end else begin
                adj[4*i +: 4] = scratch[4*i +: 4];
            end
        end
        return adj;
    endfunction

endpackage

// File: rtl/calc_result_display_if.sv
// Result bus from the calculator plus the display pins and status driven back.
// The master side supplies result; the display (slave) drives everything else.
interface calc_result_display_if #(
    parameter int NUM_BITS = 9
);
    logic [NUM_BITS-1:0] result;
    logic [6:0]          seg;
    logic [3:0]          an;
    logic                dp;
    logic [11:0]         bcd;
    logic                busy;

    modport master (output result, input seg, an, dp, bcd, busy);
    modport slave  (input result, output seg, an, dp, bcd, busy);
endinterface

// File: rtl/seg7_decoder.sv
// Combinational BCD-to-seven-segment decoder, active-low {g,f,e,d,c,b,a}.
// The blank flag, or any non-decimal nibble, turns every segment off.
module seg7_decoder
    import calc_disp_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    // Map the selected digit to its segment pattern
    always_comb begin
        seg = SEG_BLANK;
        if (blank) begin
            seg = SEG_BLANK;
        end else begin
            case (digit)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/calc_result_display.sv
// Converts each new calculator result to BCD with a sequential double-dabble
// and scans it onto the 4-digit display. Optional build: LEADING_ZERO_BLANK_EN.
module calc_result_display
    import calc_disp_pkg::*;
#(
    parameter int REFRESH_BITS = 18,
    parameter int NUM_BITS     = 9
) (
    input  logic                  clk,
    input  logic                  reset_n,
    calc_result_display_if.slave  bus
);

    localparam int CNT_W = $clog2(NUM_BITS + 1);

    state_e                  state_r;
    logic                    busy_r;
    logic [11:0]             bcd_r;
    logic [11:0]             scratch_r;
    logic [NUM_BITS-1:0]     last_val_r;
    logic [NUM_BITS-1:0]     shift_r;
    logic [CNT_W-1:0]        count_r;
    logic [REFRESH_BITS-1:0] refresh_r;
    logic [6:0]              seg_r;
    logic [NUM_DIGITS-1:0]   an_r;
    logic                    dp_r;

    logic [11:0]             adj_s;
    logic [1:0]              idx_s;
    logic [3:0]              digit_s;
    logic                    blank_s;
    logic [6:0]              seg_s;

    // Nibble correction applied before every shift step
    always_comb begin
        adj_s = dabble_adjust(scratch_r);
    end

    // Change detection and double-dabble conversion FSM
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r    <= IDLE;
            busy_r     <= 1'b0;
            bcd_r      <= 12'h000;
            scratch_r  <= 12'h000;
            last_val_r <= '0;
            shift_r    <= '0;
            count_r    <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.result != last_val_r) begin
                        shift_r    <= bus.result;
                        last_val_r <= bus.result;
                        scratch_r  <= 12'h000;
                        count_r    <= '0;
                        busy_r     <= 1'b1;
                        state_r    <= SHIFT;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SHIFT: begin
                    // The adjusted scratch's top bit is never set for in-range input
                    {scratch_r, shift_r} <= {adj_s, shift_r} << 1'b1;
                    count_r              <= count_r + 1'b1;
                    if (count_r == CNT_W'(NUM_BITS - 1)) begin
                        state_r <= DONE;
                    end else begin
                        state_r <= SHIFT;
                    end
                end
                DONE: begin
                    bcd_r   <= scratch_r;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign idx_s = refresh_r[REFRESH_BITS-1 -: 2];

    // Digit mux: pick the nibble for the active position and decide blanking
    always_comb begin
        digit_s = 4'h0;
        blank_s = 1'b1;
        case (idx_s)
            2'd0: begin
                digit_s = bcd_r[3:0];
                blank_s = 1'b0;
            end
            2'd1: begin
                digit_s = bcd_r[7:4];
`ifdef LEADING_ZERO_BLANK_EN
                blank_s = (bcd_r[11:4] == 8'h00);
`else
                blank_s = 1'b0;
`endif
            end
            2'd2: begin
                digit_s = bcd_r[11:8];
`ifdef LEADING_ZERO_BLANK_EN
                blank_s = (bcd_r[11:8] == 4'h0);
`else
                blank_s = 1'b0;
`endif
            end
            2'd3: begin
                digit_s = 4'h0;
                blank_s = 1'b1;
            end
            default: begin
                digit_s = 4'h0;
                blank_s = 1'b1;
            end
        endcase
    end

    seg7_decoder u_seg7_decoder (
        .digit (digit_s),
        .blank (blank_s),
        .seg   (seg_s)
    );

    // Free-running refresh counter and registered display pins
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            refresh_r <= '0;
            seg_r     <= SEG_BLANK;
            an_r      <= 4'hF;
            dp_r      <= 1'b1;
        end else begin
            refresh_r <= refresh_r + REFRESH_BITS'(1);
            seg_r     <= seg_s;
            an_r      <= ~(4'b0001 << idx_s);
            dp_r      <= 1'b1;
        end
    end

    assign bus.seg  = seg_r;
    assign bus.an   = an_r;
    assign bus.dp   = dp_r;
    assign bus.bcd  = bcd_r;
    assign bus.busy = busy_r;

endmodule

// File: tb/tb_calc_result_display.sv
// Self-checking bench: directed scenarios, a full 0..511 sweep and random
// result changes, checked every cycle against a decimal/timer reference model.
module tb_calc_result_display;

    logic clk;
    logic reset_n;
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   chk_en   = 1'b0;

    calc_result_display_if #(.NUM_BITS(9)) dif ();

    calc_result_display #(.REFRESH_BITS(4), .NUM_BITS(9)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    logic [3:0] an_tab  [4]  = '{4'hE, 4'hD, 4'hB, 4'h7};

    // Reference model state: value shown, pending conversion timer, scan position
    int         m_last, m_val, m_disp, m_timer, m_cnt;
    logic       m_busy;
    logic [6:0] m_seg;
    logic [3:0] m_an;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        return 12'((v / 100) * 256 + ((v / 10) % 10) * 16 + (v % 10));
    endfunction

    function automatic logic [6:0] exp_seg(input int pos, input int v);
        logic blank_lz;
`ifdef LEADING_ZERO_BLANK_EN
        blank_lz = 1'b1;
`else
        blank_lz = 1'b0;
`endif
        case (pos)
            0: return seg_tab[v % 10];
            1: return (blank_lz && v < 10)  ? 7'h7F : seg_tab[(v / 10) % 10];
            2: return (blank_lz && v < 100) ? 7'h7F : seg_tab[v / 100];
            default: return 7'h7F;
        endcase
    endfunction

    // Model update: a change seen while idle becomes visible 10 clocks later
    always @(posedge clk) begin
        if (!reset_n) begin
            m_last <= 0; m_val <= 0; m_disp <= 0; m_timer <= 0; m_cnt <= 0;
            m_busy <= 1'b0; m_seg <= 7'h7F; m_an <= 4'hF;
        end else begin
            m_cnt <= (m_cnt + 1) % 16;
            m_an  <= an_tab[m_cnt / 4];
            m_seg <= exp_seg(m_cnt / 4, m_disp);
            if (m_timer == 0) begin
                if (int'(dif.result) != m_last) begin
                    m_last  <= int'(dif.result);
                    m_val   <= int'(dif.result);
                    m_timer <= 10;
                    m_busy  <= 1'b1;
                end
            end else begin
                m_timer <= m_timer - 1;
                if (m_timer == 1) begin
                    m_disp <= m_val;
                    m_busy <= 1'b0;
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("bcd",  32'(dif.bcd),  32'(to_bcd(m_disp)));
            check("busy", 32'(dif.busy), 32'(m_busy));
            check("seg",  32'(dif.seg),  32'(m_seg));
            check("an",   32'(dif.an),   32'(m_an));
            check("dp",   32'(dif.dp),   32'd1);
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        reset_n    = 1'b0;
        dif.result = 9'd0;
        @(posedge clk);
        #1 chk_en = 1'b1;
        wait_cycles(3);
        reset_n = 1'b1;
        wait_cycles(20);
        check("idle_bcd", 32'(dif.bcd), 32'h000);
        check("idle_busy", 32'(dif.busy), 32'd0);

        // 0 -> 511: busy next edge, result exactly 10 clocks after detection
        dif.result = 9'd511;
        wait_cycles(1);
        check("busy_rise", 32'(dif.busy), 32'd1);
        wait_cycles(9);
        check("bcd_511_early", 32'(dif.bcd), 32'h000);
        wait_cycles(1);
        check("bcd_511", 32'(dif.bcd), 32'h511);
        check("busy_fall", 32'(dif.busy), 32'd0);
        wait_cycles(4);

        // Change during conversion is deferred to the next idle sample
        dif.result = 9'd255;
        wait_cycles(3);
        dif.result = 9'd37;
        wait_cycles(8);
        check("bcd_255", 32'(dif.bcd), 32'h255);
        wait_cycles(11);
        check("bcd_037", 32'(dif.bcd), 32'h037);
        wait_cycles(4);

        // Reset in the middle of a conversion aborts it cleanly
        dif.result = 9'd300;
        wait_cycles(6);
        reset_n = 1'b0;
        wait_cycles(1);
        check("abort_bcd", 32'(dif.bcd), 32'h000);
        check("abort_busy", 32'(dif.busy), 32'd0);
        reset_n = 1'b1;
        wait_cycles(11);
        check("bcd_300", 32'(dif.bcd), 32'h300);
        wait_cycles(4);

        // Digit scan of 7
        dif.result = 9'd7;
        wait_cycles(12);
        for (int i = 0; i < 16; i++) begin
            wait_cycles(1);
            if (dif.an == 4'b1110) check("scan_ones", 32'(dif.seg), 32'h78);
            if (dif.an == 4'b0111) check("scan_blank", 32'(dif.seg), 32'h7F);
`ifdef LEADING_ZERO_BLANK_EN
            if (dif.an == 4'b1011) check("scan_hund", 32'(dif.seg), 32'h7F);
            if (dif.an == 4'b1101) check("scan_tens", 32'(dif.seg), 32'h7F);
`else
            if (dif.an == 4'b1011) check("scan_hund", 32'(dif.seg), 32'h40);
            if (dif.an == 4'b1101) check("scan_tens", 32'(dif.seg), 32'h40);
`endif
        end

        // Full sweep
        for (int v = 0; v < 512; v++) begin
            dif.result = 9'(v);
            wait_cycles(12);
            check("sweep", 32'(dif.bcd), 32'(to_bcd(v)));
        end

        // Random changes, often while busy
        for (int k = 0; k < 300; k++) begin
            dif.result = 9'($urandom_range(511, 0));
            wait_cycles(int'($urandom_range(14, 1)));
        end
        dif.result = 9'd123;
        wait_cycles(25);
        check("rand_final", 32'(dif.bcd), 32'h123);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
